auto_vendor_param: RTL and testbench

- Parametrised successor to the team's fixed-menu coin vending FSM.
- Accepts coins one per cycle, holds credit, and vends one of N_DRINKS drinks, each with its own price and stock counter.
- Returns change as a serial stream of coins: one coin per cycle, largest denomination first.
- Sits between the coin acceptor front-end and the dispenser/refund actuators; all outputs registered.

---
 rtl/auto_vendor_param.sv | 221 ++++++++++++++++++++++
 tb/tb_auto_vendor_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_vendor_param.sv
// Parametrised coin vending controller: per-drink price and stock, serial change output.
// Optional AUTO_VENDOR_RESTOCK_EN adds restock_valid/restock_id to reload one drink's stock.
module auto_vendor_param #(
  parameter int COIN_W     = 6,
  parameter int SEL_W      = 3,
  parameter int N_DRINKS   = 4,
  parameter int PRICE_BASE = 10,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 50,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin,
  input  logic              choose_valid,
  input  logic [SEL_W-1:0]  drink_choose,
  input  logic              cancel,
`ifdef AUTO_VENDOR_RESTOCK_EN
  input  logic              restock_valid,
  input  logic [SEL_W-1:0]  restock_id,
`endif
  output logic [SEL_W-1:0]  give,
  output logic              give_valid,
  output logic [COIN_W-1:0] refund_coin,
  output logic              refund_valid,
  output logic [COIN_W-1:0] total_coin,
  output logic              busy,
  output logic              reject,
  output logic [N_DRINKS-1:0] sold_out,
  output logic [1:0]        state_dbg
);

  // Handshake: every input is a single-cycle qualifier sampled on the rising edge;
  // give_valid, refund_valid and reject are one-cycle registered strobes with no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  localparam int PW = COIN_W + 1;
  localparam logic [COIN_W-1:0] C1  = COIN_W'(1);
  localparam logic [COIN_W-1:0] C5  = COIN_W'(5);
  localparam logic [COIN_W-1:0] C10 = COIN_W'(10);

  function automatic logic coin_legal(input logic [COIN_W-1:0] c);
    return (c == C1) || (c == C5) || (c == C10);
  endfunction

  function automatic logic [PW-1:0] price_of(input int k);
    return PW'(PRICE_BASE + k * PRICE_STEP);
  endfunction

  state_t              state_q, state_d;
  logic [COIN_W-1:0]   credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [N_DRINKS];
  logic [STOCK_W-1:0]  stock_d [N_DRINKS];
  logic [SEL_W-1:0]    give_q, give_d;
  logic                give_valid_q, give_valid_d;
  logic [COIN_W-1:0]   refund_coin_q, refund_coin_d;
  logic                refund_valid_q, refund_valid_d;
  logic                busy_q, busy_d;
  logic                reject_q, reject_d;
  logic [N_DRINKS-1:0] sold_out_q, sold_out_d;

  logic                sel_ok;
  logic                sel_stock_ok;
  logic [PW-1:0]       sel_price;
  logic [PW-1:0]       credit_ext;
  logic [PW-1:0]       sum_ext;
  logic [COIN_W-1:0]   change_coin;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    give_d         = '0;
    give_valid_d   = 1'b0;
    refund_coin_d  = '0;
    refund_valid_d = 1'b0;
    reject_d       = 1'b0;
    sel_ok         = 1'b0;
    sel_stock_ok   = 1'b0;
    sel_price      = '0;
    change_coin    = '0;
    credit_ext     = {1'b0, credit_q};
    sum_ext        = {1'b0, credit_q} + {1'b0, coin};

    // Decode the requested id by matching; ids 0 and > N_DRINKS match nothing.
    for (int k = 0; k < N_DRINKS; k++) begin
      if (drink_choose == SEL_W'(k + 1)) begin
        sel_ok       = 1'b1;
        sel_stock_ok = (stock_q[k] != '0);
        sel_price    = price_of(k);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (coin_valid) begin
          if (coin_legal(coin)) begin
            credit_d = coin;
            state_d  = S_COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        if (cancel) begin
          state_d  = S_CHANGE;
          reject_d = coin_valid;
        end else if (choose_valid) begin
          reject_d = coin_valid;
          if (sel_ok && sel_stock_ok && (credit_ext >= sel_price)) begin
            state_d      = S_VEND;
            give_d       = drink_choose;
            give_valid_d = 1'b1;
            credit_d     = COIN_W'(credit_ext - sel_price);
            for (int k = 0; k < N_DRINKS; k++) begin
              if (drink_choose == SEL_W'(k + 1)) begin
                stock_d[k] = stock_q[k] - STOCK_W'(1);
              end
            end
          end else begin
            reject_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_legal(coin) && (sum_ext <= PW'(MAX_CREDIT))) begin
            credit_d = sum_ext[COIN_W-1:0];
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_VEND: begin
        reject_d = coin_valid;
        state_d  = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        reject_d = coin_valid;
        if (credit_q >= C10) begin
          change_coin = C10;
        end else if (credit_q >= C5) begin
          change_coin = C5;
        end else begin
          change_coin = C1;
        end
        refund_coin_d  = change_coin;
        refund_valid_d = 1'b1;
        credit_d       = credit_q - change_coin;
        if (credit_d == '0) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    for (int k = 0; k < N_DRINKS; k++) begin
      sold_out_d[k] = (stock_q[k] == '0);
    end

`ifdef AUTO_VENDOR_RESTOCK_EN
    // Applied last so a restock overrides a same-cycle vend of the same drink.
    for (int k = 0; k < N_DRINKS; k++) begin
      if (restock_valid && (restock_id == SEL_W'(k + 1))) begin
        stock_d[k]    = STOCK_W'(STOCK_INIT);
        sold_out_d[k] = 1'b0;
      end
    end
`endif

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      for (int k = 0; k < N_DRINKS; k++) begin
        stock_q[k] <= STOCK_W'(STOCK_INIT);
      end
      give_q         <= '0;
      give_valid_q   <= 1'b0;
      refund_coin_q  <= '0;
      refund_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      reject_q       <= 1'b0;
      sold_out_q     <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      give_q         <= give_d;
      give_valid_q   <= give_valid_d;
      refund_coin_q  <= refund_coin_d;
      refund_valid_q <= refund_valid_d;
      busy_q         <= busy_d;
      reject_q       <= reject_d;
      sold_out_q     <= sold_out_d;
    end
  end

  assign give         = give_q;
  assign give_valid   = give_valid_q;
  assign refund_coin  = refund_coin_q;
  assign refund_valid = refund_valid_q;
  assign total_coin   = credit_q;
  assign busy         = busy_q;
  assign reject       = reject_q;
  assign sold_out     = sold_out_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_auto_vendor_param.sv
// Scoreboard bench for auto_vendor_param: stimulus pushes expected strobes, a negedge monitor pops them.
// Define AUTO_VENDOR_RESTOCK_EN for both bench and RTL to exercise the restock ports.
module tb_auto_vendor_param;

  logic       clk;
  logic       reset;
  logic       coin_valid;
  logic [5:0] coin;
  logic       choose_valid;
  logic [2:0] drink_choose;
  logic       cancel;
`ifdef AUTO_VENDOR_RESTOCK_EN
  logic       restock_valid;
  logic [2:0] restock_id;
`endif
  logic [2:0] give;
  logic       give_valid;
  logic [5:0] refund_coin;
  logic       refund_valid;
  logic [5:0] total_coin;
  logic       busy;
  logic       reject;
  logic [3:0] sold_out;
  logic [1:0] state_dbg;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Entry = {kind, value}: kind 1 = give, 2 = refund, 3 = reject.
  logic [7:0] exp_q[$];

  auto_vendor_param dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin         (coin),
    .choose_valid (choose_valid),
    .drink_choose (drink_choose),
    .cancel       (cancel),
`ifdef AUTO_VENDOR_RESTOCK_EN
    .restock_valid(restock_valid),
    .restock_id   (restock_id),
`endif
    .give         (give),
    .give_valid   (give_valid),
    .refund_coin  (refund_coin),
    .refund_valid (refund_valid),
    .total_coin   (total_coin),
    .busy         (busy),
    .reject       (reject),
    .sold_out     (sold_out),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [7:0] act);
    logic [7:0] e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      bad_cnt++;
      $display("FAIL %s: unexpected strobe value %0d with empty queue", name, act[5:0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        bad_cnt++;
        $display("FAIL %s: got kind %0d value %0d expected kind %0d value %0d",
                 name, act[7:6], act[5:0], e[7:6], e[5:0]);
      end
    end
  endtask

  function automatic logic [7:0] ev_give(input logic [2:0] id);
    return {2'd1, 3'd0, id};
  endfunction
  function automatic logic [7:0] ev_refund(input logic [5:0] c);
    return {2'd2, c};
  endfunction
  function automatic logic [7:0] ev_reject();
    return {2'd3, 6'd0};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (give_valid) pop_cmp("give", {2'd1, 3'd0, give});
      else chk("give_idle_zero", {29'd0, give}, 32'd0);
      if (refund_valid) pop_cmp("refund", {2'd2, refund_coin});
      else chk("refund_idle_zero", {26'd0, refund_coin}, 32'd0);
      if (reject) pop_cmp("reject", {2'd3, 6'd0});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic cv, input logic [5:0] c, input logic chv,
                     input logic [2:0] ch, input logic can);
    coin_valid   = cv;
    coin         = c;
    choose_valid = chv;
    drink_choose = ch;
    cancel       = can;
    @(posedge clk);
    #1;
    coin_valid   = 1'b0;
    coin         = 6'd0;
    choose_valid = 1'b0;
    drink_choose = 3'd0;
    cancel       = 1'b0;
  endtask

  task automatic put_coin(input logic [5:0] c);
    cyc(1'b1, c, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic choose(input logic [2:0] id);
    cyc(1'b0, 6'd0, 1'b1, id, 1'b0);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 6'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 30; i++) begin
      if (!busy && state_dbg == 2'd0) break;
      idle_cyc();
    end
    chk(name, {30'd0, busy, state_dbg != 2'd0}, 32'd0);
  endtask

`ifdef AUTO_VENDOR_RESTOCK_EN
  task automatic restock(input logic [2:0] id);
    restock_valid = 1'b1;
    restock_id    = id;
    @(posedge clk);
    #1;
    restock_valid = 1'b0;
    restock_id    = 3'd0;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b0;
    coin_valid   = 1'b0;
    coin         = 6'd0;
    choose_valid = 1'b0;
    drink_choose = 3'd0;
    cancel       = 1'b0;
`ifdef AUTO_VENDOR_RESTOCK_EN
    restock_valid = 1'b0;
    restock_id    = 3'd0;
`endif
    #3;
    chk("reset_outputs", {give, give_valid, refund_coin, refund_valid, total_coin,
                          busy, reject, sold_out, state_dbg}, 32'd0);
    #9;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Coins 5,5,1,1,10 then drink 2 (price 15): change 7 = 5,1,1
    put_coin(6'd5); put_coin(6'd5); put_coin(6'd1); put_coin(6'd1); put_coin(6'd10);
    chk("credit_22", total_coin, 32'd22);
    exp_q.push_back(ev_give(3'd2));
    exp_q.push_back(ev_refund(6'd5));
    exp_q.push_back(ev_refund(6'd1));
    exp_q.push_back(ev_refund(6'd1));
    choose(3'd2);
    chk("vend_busy", busy, 32'd1);
    chk("vend_credit_7", total_coin, 32'd7);
    idle_cyc();
    chk("change_state", state_dbg, 32'd3);
    wait_idle("idle_after_t1");
    chk("credit_0_t1", total_coin, 32'd0);

    // Insufficient credit for drink 4 (price 25), then cancel
    put_coin(6'd10);
    exp_q.push_back(ev_reject());
    choose(3'd4);
    chk("no_give_poor", give_valid, 32'd0);
    chk("credit_kept_10", total_coin, 32'd10);
    exp_q.push_back(ev_refund(6'd10));
    cyc(1'b0, 6'd0, 1'b0, 3'd0, 1'b1);
    wait_idle("idle_after_t2");
    chk("credit_0_t2", total_coin, 32'd0);

    // Illegal coin and credit-ceiling overflow
    put_coin(6'd10);
    exp_q.push_back(ev_reject());
    put_coin(6'd3);
    chk("illegal_coin_credit", total_coin, 32'd10);
    put_coin(6'd10); put_coin(6'd10); put_coin(6'd10); put_coin(6'd5);
    chk("credit_45", total_coin, 32'd45);
    exp_q.push_back(ev_reject());
    put_coin(6'd10);
    chk("overflow_credit", total_coin, 32'd45);
    exp_q.push_back(ev_refund(6'd10));
    exp_q.push_back(ev_refund(6'd10));
    exp_q.push_back(ev_refund(6'd10));
    exp_q.push_back(ev_refund(6'd10));
    exp_q.push_back(ev_refund(6'd5));
    cyc(1'b0, 6'd0, 1'b0, 3'd0, 1'b1);
    wait_idle("idle_after_t3");

    // Five exact purchases of drink 1 exhaust its stock
    for (int n = 0; n < 5; n++) begin
      chk("sold_out_before", sold_out, 32'd0);
      put_coin(6'd10);
      exp_q.push_back(ev_give(3'd1));
      choose(3'd1);
      wait_idle("idle_after_buy");
    end
    chk("sold_out_drink1", sold_out, 32'd1);
    put_coin(6'd10);
    exp_q.push_back(ev_reject());
    choose(3'd1);
    chk("sold_out_credit_kept", total_coin, 32'd10);
    exp_q.push_back(ev_refund(6'd10));
    cyc(1'b0, 6'd0, 1'b0, 3'd0, 1'b1);
    wait_idle("idle_after_t4");

`ifdef AUTO_VENDOR_RESTOCK_EN
    restock(3'd1);
    idle_cyc();
    chk("restock_clears", sold_out, 32'd0);
    put_coin(6'd10);
    exp_q.push_back(ev_give(3'd1));
    choose(3'd1);
    wait_idle("idle_after_restock_buy");
`endif

    // Accepted choose with a coin in the same cycle: coin refused, change 5
    put_coin(6'd10); put_coin(6'd10);
    exp_q.push_back(ev_give(3'd2));
    exp_q.push_back(ev_reject());
    exp_q.push_back(ev_refund(6'd5));
    cyc(1'b1, 6'd5, 1'b1, 3'd2, 1'b0);
    chk("choose_coin_credit", total_coin, 32'd5);
    wait_idle("idle_after_t5a");

    // Cancel beats choose and coin in the same cycle
    put_coin(6'd10); put_coin(6'd10);
    exp_q.push_back(ev_reject());
    exp_q.push_back(ev_refund(6'd10));
    exp_q.push_back(ev_refund(6'd10));
    cyc(1'b1, 6'd5, 1'b1, 3'd2, 1'b1);
    chk("cancel_wins_state", state_dbg, 32'd3);
    wait_idle("idle_after_t5b");

    // Credit 28, drink 3 (price 20) -> change 8; reset after the first refund
    put_coin(6'd10); put_coin(6'd10); put_coin(6'd5);
    put_coin(6'd1); put_coin(6'd1); put_coin(6'd1);
    chk("credit_28", total_coin, 32'd28);
    exp_q.push_back(ev_give(3'd3));
    exp_q.push_back(ev_refund(6'd5));
    choose(3'd3);
    idle_cyc();
    idle_cyc();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_outputs", {give, give_valid, refund_coin, refund_valid, total_coin,
                          busy, reject, sold_out, state_dbg}, 32'd0);
    chk("abort_queue_drained", exp_q.size(), 32'd0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    put_coin(6'd10);
    exp_q.push_back(ev_give(3'd1));
    choose(3'd1);
    wait_idle("idle_after_reload_buy");
    chk("reload_credit_0", total_coin, 32'd0);
    chk("reload_sold_out", sold_out, 32'd0);

    idle_cyc();
    idle_cyc();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
